// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response bundle for alu_arbiter.
// slave = arbiter side, master = requesters/ALU/environment side.
interface alu_arbiter_if #(
  parameter int DW  = 8,
  parameter int OPW = 4
);
  logic           req0_valid;
  logic           req1_valid;
  logic [OPW-1:0] req0_op;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic           req0_ready;
  logic           req1_ready;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_r;
  logic [2:0]     alu_flags;
  logic           rsp0_done;
  logic           rsp1_done;
  logic [DW-1:0]  rsp_r;
  logic [2:0]     rsp_flags;
  logic           rsp_err;
  logic           busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, alu_r, alu_flags,
    output req0_ready, req1_ready, alu_op, alu_a, alu_b,
           rsp0_done, rsp1_done, rsp_r, rsp_flags, rsp_err, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, alu_r, alu_flags,
    input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
           rsp0_done, rsp1_done, rsp_r, rsp_flags, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           grant_q;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q, b_q;
  logic [DW-1:0]  r_q;
  logic [2:0]     flags_q;
  logic           err_q;
  logic           pick;
  logic           idle;
  logic           accept;
  logic           illegal;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // On a tie the requester that did not win last time goes first.
  assign pick = bus.req1_valid & (~bus.req0_valid | ~last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= pick;
    end
  end
`else
  assign pick = bus.req1_valid & ~bus.req0_valid;
`endif

  assign idle           = (state_q == IDLE) & ~rst;
  assign bus.req0_ready = idle & bus.req0_valid & ~pick;
  assign bus.req1_ready = idle & bus.req1_valid & pick;
  assign accept         = bus.req0_ready | bus.req1_ready;

  assign illegal = (op_q == {OPW{1'b0}}) || (op_q == OPW'(4'b1110));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= pick;
        op_q    <= pick ? bus.req1_op : bus.req0_op;
        a_q     <= pick ? bus.req1_a  : bus.req0_a;
        b_q     <= pick ? bus.req1_b  : bus.req0_b;
      end
      // Response registers only move at the end of EXEC, so they hold everywhere else.
      if (state_q == EXEC) begin
        if (illegal) begin
          r_q     <= '0;
          flags_q <= 3'b000;
          err_q   <= 1'b1;
        end else begin
          r_q     <= bus.alu_r;
          flags_q <= bus.alu_flags;
          err_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp0_done = (state_q == RESP) & ~grant_q;
  assign bus.rsp1_done = (state_q == RESP) & grant_q;
  assign bus.rsp_r     = r_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a bench-side ALU and a response scoreboard.
// Honours ALU_ARB_RR_EN to select the expected tie-breaking policy.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic       g;
    logic [7:0] r;
    logic [2:0] f;
    logic       e;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  logic tb_last;
  exp_t sb[$];

  alu_arbiter_if #(.DW(8), .OPW(4)) bus ();

  alu_arbiter #(.DW(8), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: {neg, zero, ovf, r}
  function automatic logic [10:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       v;
    r = a;
    v = 1'b0;
    case (op)
      4'b1000: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'b1001: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'b1010: r = a & b;
      4'b1011: r = a | b;
      4'b1100: r = a ^ b;
      default: r = a;
    endcase
    return {r[7], (r == 8'h00), v, r};
  endfunction

  always_comb {bus.alu_flags, bus.alu_r} = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp0_done === 1'b1 || bus.rsp1_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {30'd0, bus.rsp0_done, bus.rsp1_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done0", bus.rsp0_done, !e.g);
        chk("done1", bus.rsp1_done, e.g);
        chk("rsp_r", bus.rsp_r, e.r);
        chk("rsp_flags", bus.rsp_flags, e.f);
        chk("rsp_err", bus.rsp_err, e.e);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic v0, input logic v1,
                       input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
  endtask

  // Called at posedge+1 in IDLE. keep holds both requests across the operation;
  // track=0 stops after the accept edge (caller aborts the operation).
  task automatic issue(input logic v0, input logic v1,
                       input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                       input bit keep, input bit track);
    exp_t        e;
    logic        g;
    logic [3:0]  opg;
    logic [7:0]  ag, bg;
    logic [10:0] m;
    drive(v0, v1, op0, a0, b0, op1, a1, b1);
    #1;
    if (v0 && v1) g = RR ? !tb_last : 1'b0;
    else          g = v1;
    chk("ready0", bus.req0_ready, !g);
    chk("ready1", bus.req1_ready, g);
    tb_last = g;
    opg = g ? op1 : op0;
    ag  = g ? a1 : a0;
    bg  = g ? b1 : b0;
    if (opg == 4'b0000 || opg == 4'b1110) begin
      e.r = 8'h00; e.f = 3'b000; e.e = 1'b1;
    end else begin
      m = alu_model(opg, ag, bg);
      e.r = m[7:0]; e.f = m[10:8]; e.e = 1'b0;
    end
    e.g   = g;
    e.cyc = cyc + 2;
    if (track) sb.push_back(e);
    @(posedge clk); #1;
    if (!keep) drive(1'b0, 1'b0, 4'b1100, 8'hFF, 8'hA5, 4'b1100, 8'hFF, 8'h5A);
    chk("busy_exec", bus.busy, 1'b1);
    chk("holdoff0", bus.req0_ready, 1'b0);
    chk("holdoff1", bus.req1_ready, 1'b0);
    if (track) begin
      @(posedge clk); #1;
      chk("busy_resp", bus.busy, 1'b1);
      @(posedge clk); #1;
      chk("busy_idle", bus.busy, 1'b0);
      chk("hold_r", bus.rsp_r, e.r);
      chk("hold_err", bus.rsp_err, e.e);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    tb_last = 1'b1;
    rst     = 1'b1;
    drive(1'b1, 1'b1, 4'b1000, 8'h11, 8'h22, 4'b1000, 8'h33, 8'h44);
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_done", {bus.rsp0_done, bus.rsp1_done}, 2'b00);
    chk("rst_rsp_r", bus.rsp_r, 8'h00);
    chk("rst_flags", bus.rsp_flags, 3'b000);
    chk("rst_err", bus.rsp_err, 1'b0);
    chk("rst_alu_op", bus.alu_op, 4'h0);
    chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 16'h0000);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Continuous contention: RR alternates 0,1,0,1; fixed priority starves req1.
    for (int i = 0; i < 4; i++)
      issue(1'b1, 1'b1, 4'b1010, 8'hF0, 8'h3C, 4'b1011, 8'h0F, 8'h30, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00);

    issue(1'b1, 1'b0, 4'b1000, 8'h05, 8'h03, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'b1001, 8'h04, 8'h04, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 4'b1110, 8'h12, 8'h34, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'b0000, 8'h77, 8'h01, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 4'b1000, 8'h7F, 8'h01, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'b1100, 8'hAA, 8'h0F, 1'b0, 1'b1);

    // Valid withdrawn before any edge: nothing accepted.
    bus.req0_valid = 1'b1;
    #1;
    chk("ready0_pre", bus.req0_ready, 1'b1);
    #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("withdraw_busy", bus.busy, 1'b0);

    // Reset during EXEC aborts the operation; no done may follow.
    issue(1'b1, 1'b0, 4'b1000, 8'h21, 8'h02, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_ready1", bus.req1_ready, 1'b0);
    chk("abort_rsp_r", bus.rsp_r, 8'h00);
    tb_last = 1'b1;
    repeat (2) @(posedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'b1000, 8'h10, 8'h20, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
